key_search_ctrl: RTL and testbench
==================================

KEY_SEARCH_CTRL -- requirements
Module: key_search_ctrl

Interface
REQ-001 Parameter KEY_W, default 24, key width in bits; taken from the shared package.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 go  input  1  one-cycle request to start a search; honoured only in IDLE, DONE_FOUND or DONE_EXH.
REQ-005 key_lo  input  KEY_W  inclusive first key, sampled on accepted go.
REQ-006 key_hi  input  KEY_W  inclusive last key, sampled on accepted go.
REQ-007 abort  input  1  cancels a search from any state.
REQ-008 core_key  output  KEY_W  key presented to the arcfour core (its switch_key).
REQ-009 core_start  output  1  start level to the arcfour core.
REQ-010 core_finished  input  1  arcfour completed decryption with all bytes valid.
REQ-011 core_terminated  input  1  arcfour stopped on an invalid output byte.
REQ-012 busy  output  1  high from the cycle after accepted go until DONE or IDLE.
REQ-013 found  output  1  high in DONE_FOUND.
REQ-014 exhausted  output  1  high in DONE_EXH.
REQ-015 found_key  output  KEY_W  key that produced core_finished; valid while found.
REQ-016 attempts  output  KEY_W+1  number of keys fully tried (finished or terminated) since accepted go.

Function
REQ-017 States: IDLE, RUN, DROP, DONE_FOUND, DONE_EXH.
REQ-018 IDLE + go with key_lo <= key_hi: next cycle RUN, core_key = key_lo, core_start = 1, busy = 1, attempts = 0, found = exhausted = 0.
REQ-019 IDLE/DONE + go with key_lo > key_hi: next cycle DONE_EXH, attempts = 0, core_start stays 0.
REQ-020 RUN: core_start held 1 until core_finished or core_terminated sampled high.
REQ-021 RUN, core_finished=1 and core_terminated=0: next cycle DONE_FOUND, found_key = core_key, attempts += 1, core_start = 0.
REQ-022 RUN, core_terminated=1 (takes priority over simultaneous core_finished): attempts += 1, core_start = 0; if core_key == key_hi next state DONE_EXH, else next state DROP with core_key += 1.
REQ-023 DROP lasts exactly one cycle with core_start = 0, then RUN with core_start = 1 on the new key.
REQ-024 Compare-before-increment: key_hi = all-ones never wraps core_key; attempts width covers the full 2^KEY_W range without overflow.
REQ-025 DONE_FOUND/DONE_EXH hold all outputs until abort or accepted go; go there restarts per REQ-018/019.
REQ-026 go while busy is ignored; key_lo/key_hi changes while busy have no effect.
REQ-027 abort in any state: next cycle IDLE, core_start = 0, busy = found = exhausted = 0; core_key, found_key and attempts keep their values; abort wins over simultaneous go.
REQ-028 core_finished/core_terminated outside RUN are ignored.

Reset
REQ-029 Reset low forces IDLE immediately; core_start, busy, found and exhausted = 0; core_key, found_key and attempts = 0.
REQ-030 Reset mid-search abandons the search; no output returns high until a new go after reset release.

Structure
REQ-031 The shared package holds KEY_W and the state enum type; the block imports both.
REQ-032 Single module, no sub-modules; the key counter and the attempts counter are inline registers.

Verification
REQ-033 key_lo=0x000010, key_hi=0x000012, core terminates twice then finishes on 0x000012 -> found=1, found_key=0x000012, attempts=3, one core_start low cycle between keys.
REQ-034 key_lo=0x000000, key_hi=0x000003, core always terminates -> exhausted=1, attempts=4, core_key=0x000003, found=0.
REQ-035 key_lo=0x000005, key_hi=0x000004 -> exhausted=1 the cycle after go, attempts=0, core_start never high.
REQ-036 key_lo=key_hi=0xFFFFFF, core terminates -> exhausted=1, core_key=0xFFFFFF (no wrap), attempts=1.
REQ-037 core_finished and core_terminated both high on key 0x000007 (range 0x000007..0x000008) -> core_key advances to 0x000008, found stays 0.
REQ-038 abort during RUN at key 0x000020, then reset low mid-search -> IDLE, core_start=0 the next cycle; after reset, all outputs 0 until a new go.

Source files
------------

// File: rtl/key_search_ctrl_pkg.sv
// Shared key width and controller state encoding for the key search controller.
package key_search_ctrl_pkg;

    localparam int unsigned KEY_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RUN        = 3'd1,
        ST_DROP       = 3'd2,
        ST_DONE_FOUND = 3'd3,
        ST_DONE_EXH   = 3'd4
    } state_e;

endpackage

// File: rtl/key_search_ctrl.sv
// Sequences an arcfour core through an inclusive key range until a key
// decrypts cleanly (found) or the range runs out (exhausted).
module key_search_ctrl
    import key_search_ctrl_pkg::*;
#(
    parameter int unsigned KEY_W = key_search_ctrl_pkg::KEY_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [KEY_W-1:0] key_lo,
    input  logic [KEY_W-1:0] key_hi,
    input  logic             abort,
    output logic [KEY_W-1:0] core_key,
    output logic             core_start,
    input  logic             core_finished,
    input  logic             core_terminated,
    output logic             busy,
    output logic             found,
    output logic             exhausted,
    output logic [KEY_W-1:0] found_key,
    output logic [KEY_W:0]   attempts
);

    localparam int unsigned CNT_W = KEY_W + 1;

    state_e             state_q,      state_d;
    logic [KEY_W-1:0]   key_hi_q,     key_hi_d;
    logic [KEY_W-1:0]   core_key_q,   core_key_d;
    logic [KEY_W-1:0]   found_key_q,  found_key_d;
    logic [CNT_W-1:0]   attempts_q,   attempts_d;
    logic               core_start_q, core_start_d;
    logic               busy_q,       busy_d;
    logic               found_q,      found_d;
    logic               exhausted_q,  exhausted_d;

    // Next-state, key/attempt counters and registered status decode.
    always_comb begin
        state_d     = state_q;
        key_hi_d    = key_hi_q;
        core_key_d  = core_key_q;
        found_key_d = found_key_q;
        attempts_d  = attempts_q;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE_FOUND, ST_DONE_EXH: begin
                    if (go) begin
                        attempts_d = '0;
                        if (key_lo <= key_hi) begin
                            state_d    = ST_RUN;
                            core_key_d = key_lo;
                            key_hi_d   = key_hi;
                        end else begin
                            state_d = ST_DONE_EXH;
                        end
                    end
                end
                ST_RUN: begin
                    // Terminated outranks finished; compare before increment so
                    // an all-ones upper bound never wraps the key.
                    if (core_terminated) begin
                        attempts_d = attempts_q + CNT_W'(1);
                        if (core_key_q == key_hi_q) begin
                            state_d = ST_DONE_EXH;
                        end else begin
                            state_d    = ST_DROP;
                            core_key_d = core_key_q + KEY_W'(1);
                        end
                    end else if (core_finished) begin
                        attempts_d  = attempts_q + CNT_W'(1);
                        found_key_d = core_key_q;
                        state_d     = ST_DONE_FOUND;
                    end
                end
                ST_DROP: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        core_start_d = (state_d == ST_RUN);
        busy_d       = (state_d == ST_RUN) || (state_d == ST_DROP);
        found_d      = (state_d == ST_DONE_FOUND);
        exhausted_d  = (state_d == ST_DONE_EXH);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            key_hi_q     <= '0;
            core_key_q   <= '0;
            found_key_q  <= '0;
            attempts_q   <= '0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_hi_q     <= key_hi_d;
            core_key_q   <= core_key_d;
            found_key_q  <= found_key_d;
            attempts_q   <= attempts_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            found_q      <= found_d;
            exhausted_q  <= exhausted_d;
        end
    end

    assign core_key   = core_key_q;
    assign core_start = core_start_q;
    assign busy       = busy_q;
    assign found      = found_q;
    assign exhausted  = exhausted_q;
    assign found_key  = found_key_q;
    assign attempts   = attempts_q;

endmodule

// File: tb/tb_key_search_ctrl.sv
// Scoreboard bench: searches are predicted by walking the key range, and a
// monitor checks each completion plus the one-cycle gap between keys.
module tb_key_search_ctrl;
    import key_search_ctrl_pkg::*;

    localparam int unsigned KW   = KEY_W;
    localparam int unsigned AW   = KW + 1;
    localparam int unsigned NONE = 32'hFFFF_FFFF;
    localparam logic [KW-1:0] KMAX = '1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          go = 1'b0;
    logic          abort = 1'b0;
    logic          core_finished = 1'b0;
    logic          core_terminated = 1'b0;
    logic [KW-1:0] key_lo = '0;
    logic [KW-1:0] key_hi = '0;
    logic [KW-1:0] core_key;
    logic [KW-1:0] found_key;
    logic          core_start;
    logic          busy;
    logic          found;
    logic          exhausted;
    logic [AW-1:0] attempts;

    typedef struct {
        bit            fnd;
        logic [KW-1:0] fkey;
        logic [AW-1:0] att;
        logic [KW-1:0] ckey;
    } exp_t;

    exp_t          sb_q[$];
    int            total = 0;
    int            bad = 0;
    int unsigned   tgt_key = NONE;
    int unsigned   both_key = NONE;
    logic [KW-1:0] model_ckey = '0;
    int            core_lat = 0;
    logic          mon_pf = 1'b0;
    logic          mon_pe = 1'b0;
    int            mon_gap = 0;

    always #5 clk = ~clk;

    key_search_ctrl #(.KEY_W(KW)) dut (
        .clk             (clk),
        .reset           (reset),
        .go              (go),
        .key_lo          (key_lo),
        .key_hi          (key_hi),
        .abort           (abort),
        .core_key        (core_key),
        .core_start      (core_start),
        .core_finished   (core_finished),
        .core_terminated (core_terminated),
        .busy            (busy),
        .found           (found),
        .exhausted       (exhausted),
        .found_key       (found_key),
        .attempts        (attempts)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: walk the range; the first key answering finished-only wins.
    function automatic exp_t model(input logic [KW-1:0] lo, input logic [KW-1:0] hi,
                                   input int unsigned tgt, input int unsigned bth,
                                   input logic [KW-1:0] prev_ckey);
        exp_t e;
        e.fnd  = 1'b0;
        e.fkey = '0;
        e.att  = '0;
        e.ckey = prev_ckey;
        if (lo > hi) return e;
        for (longint k = longint'(lo); k <= longint'(hi); k++) begin
            e.att  = AW'(k - longint'(lo) + 1);
            e.ckey = KW'(k);
            if (k == longint'(tgt) && k != longint'(bth)) begin
                e.fnd  = 1'b1;
                e.fkey = KW'(k);
                return e;
            end
        end
        return e;
    endfunction

    // Arcfour core stand-in: answers after a random delay, plus stray pulses while idle.
    initial begin
        forever begin
            @(negedge clk);
            core_finished   = 1'b0;
            core_terminated = 1'b0;
            if (core_start) begin
                if (core_lat == 0) begin
                    if (32'(core_key) == both_key) begin
                        core_finished   = 1'b1;
                        core_terminated = 1'b1;
                    end else if (32'(core_key) == tgt_key) begin
                        core_finished = 1'b1;
                    end else begin
                        core_terminated = 1'b1;
                    end
                    core_lat = int'($urandom_range(0, 2));
                end else begin
                    core_lat--;
                end
            end else if ($urandom_range(0, 5) == 0) begin
                core_finished   = 1'($urandom_range(0, 1));
                core_terminated = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: pop on each completion; check single DROP cycle between keys.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if ((found && !mon_pf) || (exhausted && !mon_pe)) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_empty: completion with no expected entry, found=%0b exhausted=%0b", found, exhausted);
                    end else begin
                        e = sb_q.pop_front();
                        check("found", 64'(found), 64'(e.fnd));
                        check("exhausted", 64'(exhausted), 64'(!e.fnd));
                        if (e.fnd) check("found_key", 64'(found_key), 64'(e.fkey));
                        check("attempts", 64'(attempts), 64'(e.att));
                        check("core_key", 64'(core_key), 64'(e.ckey));
                        check("done_busy", 64'(busy), 64'(0));
                        check("done_core_start", 64'(core_start), 64'(0));
                    end
                end
                if (busy && !core_start) begin
                    mon_gap++;
                end else if (busy && core_start) begin
                    if (mon_gap != 0) check("drop_gap", 64'(mon_gap), 64'(1));
                    mon_gap = 0;
                end else begin
                    mon_gap = 0;
                end
            end else begin
                mon_gap = 0;
            end
            mon_pf = found;
            mon_pe = exhausted;
        end
    end

    task automatic do_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic run_search(input logic [KW-1:0] lo, input logic [KW-1:0] hi,
                              input int unsigned tgt, input int unsigned bth,
                              input int budget, output int lat);
        exp_t e;
        int   n;
        @(negedge clk);
        // Restarting DONE_EXH into DONE_EXH shows no edge; pass through IDLE.
        if (exhausted && lo > hi) do_abort();
        e = model(lo, hi, tgt, bth, model_ckey);
        model_ckey = e.ckey;
        sb_q.push_back(e);
        tgt_key  = tgt;
        both_key = bth;
        key_lo   = lo;
        key_hi   = hi;
        go       = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n  = 0;
        while (!(found || exhausted) && n < budget) begin
            @(negedge clk);
            n++;
            if (busy && $urandom_range(0, 7) == 0) begin
                go     = 1'b1;
                key_lo = KW'($urandom);
                key_hi = KW'($urandom);
            end else begin
                go = 1'b0;
            end
        end
        go  = 1'b0;
        lat = n;
        if (!(found || exhausted)) begin
            total++;
            bad++;
            $display("FAIL timeout: search %0h..%0h not done after %0d cycles", lo, hi, n);
        end
    endtask

    initial begin
        int            lat;
        int            n;
        int unsigned   len;
        int unsigned   tgt;
        int unsigned   bth;
        longint        h;
        logic [KW-1:0] lo;
        logic [KW-1:0] hi;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_core_start", 64'(core_start), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_found", 64'(found), 64'(0));
        check("rst_exhausted", 64'(exhausted), 64'(0));
        check("rst_core_key", 64'(core_key), 64'(0));
        check("rst_found_key", 64'(found_key), 64'(0));
        check("rst_attempts", 64'(attempts), 64'(0));
        reset = 1'b1;

        // Two terminations then a hit on the last key; outputs then hold
        run_search(KW'(24'h10), KW'(24'h12), 32'h12, NONE, 200, lat);
        repeat (3) @(negedge clk);
        check("hold_found", 64'(found), 64'(1));
        check("hold_found_key", 64'(found_key), 64'(24'h12));
        check("hold_attempts", 64'(attempts), 64'(3));

        // Whole range terminates
        run_search(KW'(0), KW'(3), NONE, NONE, 200, lat);

        // Empty range: exhausted the cycle after go, core never started
        run_search(KW'(5), KW'(4), NONE, NONE, 50, lat);
        check("empty_latency", 64'(lat), 64'(0));
        check("empty_core_start", 64'(core_start), 64'(0));

        // Top of key space must not wrap
        run_search(KMAX, KMAX, NONE, NONE, 50, lat);

        // Simultaneous finished+terminated counts as a termination
        run_search(KW'(7), KW'(8), 32'h7, 32'h7, 100, lat);

        // Randomized searches
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) lo = KW'(longint'(KMAX) - longint'($urandom_range(0, 12)));
            else                           lo = KW'($urandom_range(0, 60));
            len = $urandom_range(0, 12);
            h = longint'(lo) + longint'(len);
            if (h > longint'(KMAX)) h = longint'(KMAX);
            hi = KW'(h);
            if (lo != '0 && $urandom_range(0, 6) == 0) hi = lo - KW'(1);
            tgt = ($urandom_range(0, 3) == 0) ? NONE : 32'(lo) + $urandom_range(0, len + 2);
            if ($urandom_range(0, 3) == 0)      bth = tgt;
            else if ($urandom_range(0, 1) == 0) bth = NONE;
            else                                bth = 32'(lo) + $urandom_range(0, len);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                do_abort();
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_search(lo, hi, tgt, bth, 600, lat);
        end

        // Abort mid-run at key 0x20: status drops, key and count retained
        @(negedge clk);
        tgt_key  = NONE;
        both_key = NONE;
        key_lo   = KW'(24'h1C);
        key_hi   = KW'(24'h40);
        go       = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n  = 0;
        while (!(core_start && core_key == KW'(24'h20)) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_key", 64'(core_key), 64'(24'h20));
        go = 1'b1;
        do_abort();
        go = 1'b0;
        check("abort_core_start", 64'(core_start), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_found", 64'(found), 64'(0));
        check("abort_exhausted", 64'(exhausted), 64'(0));
        check("abort_core_key", 64'(core_key), 64'(24'h20));
        check("abort_attempts", 64'(attempts), 64'(4));
        model_ckey = KW'(24'h20);

        // Reset in the middle of a search
        key_lo = KW'(24'h30);
        key_hi = KW'(24'h50);
        go     = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_core_start", 64'(core_start), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_core_key", 64'(core_key), 64'(0));
        check("mid_rst_attempts", 64'(attempts), 64'(0));
        @(negedge clk);
        reset      = 1'b1;
        model_ckey = '0;
        for (int c = 0; c < 5; c++) begin
            key_lo = KW'($urandom);
            @(negedge clk);
            check("post_rst_quiet",
                  64'({core_start, busy, found, exhausted, core_key, found_key, attempts}), 64'(0));
        end

        // Recovery after reset
        run_search(KW'(1), KW'(2), 32'h2, NONE, 100, lat);
        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_leftover: %0d expected completions never seen", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
